funnel_ctrl_1_3: RTL and testbench
==================================

Name: funnel_ctrl_1_3

Overview:
- Width-splitting stage that sits directly upstream of defunnel_ctrl_3_1.
- Accepts one 4-slot wide word on target port t_0 and serialises it onto one narrow initiator lane (i_0) or two narrow initiator lanes (i_0, i_1).
- mode[1:0] selects the reduction, with the same encoding as the downstream defunnel, so the pair round-trips a word.
- Includes the holding register, slot-valid tracking, beat pointer and req/ack handshakes.

Parameters:
- W, 8, width of one slot/lane in bits; wide word is 4*W.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- t_0_req  input  1  wide word offered
- t_0_ack  output  1  wide word accepted this cycle
- t_0_dat  input  4*W  wide word; slot k = bits [k*W +: W]
- t_cfg_req  input  1  config request
- t_cfg_ack  output  1  config ack; tied 1
- i_0_req  output  1  lane-0 beat valid
- i_0_ack  input  1  lane-0 beat taken
- i_0_dat  output  W  lane-0 slot data
- i_1_req  output  1  lane-1 beat valid (dual mode only)
- i_1_ack  input  1  lane-1 beat taken
- i_1_dat  output  W  lane-1 slot data
- mode  input  8  mode[1:0] = reduct; bits [7:2] ignored
- busy  output  1  holding register has any valid slot

Behaviour:
- Transfer rule: a transfer occurs on a port when req & ack are both high in a cycle. Ack may depend combinationally on req.
- Mode decode: reduct[0]=1 -> single (one slot per beat); else reduct[1]=1 -> dual (two slots per beat); 00 -> idle. Mode 11 therefore means single.
- State registers:
  - buf[4*W]
  - valid[3:0]
  - ptr[1:0]
  - mode_q[1:0], the mode latched at word capture
- Beat outputs:
  - i_0_req = valid[ptr]; i_0_dat = buf slot ptr.
  - i_1_req = mode_q dual & valid[ptr+1]; i_1_dat = buf slot ptr+1 in dual, 0 in single.
- Beat fire:
  - single: i_0_req & i_0_ack.
  - dual: i_0_req & i_0_ack & i_1_req & i_1_ack. Both lanes are acked jointly; a lone ack on one lane is not a fire, and both reqs stay high with unchanged data.
- On fire:
  - clear valid[ptr] (and valid[ptr+1] in dual).
  - ptr += 1 (single) or += 2 (dual), modulo 4.
- Last beat: ptr==3 in single, ptr==2 in dual, and that beat fires.
- Word acceptance:
  - t_0_ack = t_0_req & (reduct != 00) & (valid==0 | last_beat_fire).
  - On acceptance: buf<=t_0_dat, valid<=4'b1111, ptr<=0, mode_q<=reduct.
  - Accept on the last-beat cycle has priority over the valid clear, giving zero-bubble back-to-back words.
- Latency: word accepted in cycle N -> first beat req high in N+1. Full word takes 4 beats (single) or 2 beats (dual) with no backpressure.
- Mode mid-word: a mode change while valid != 0 has no effect until the next acceptance; mode_q governs the draining word.
- Idle mode: reduct=00 -> t_0_ack=0. A word already held still drains under mode_q.
- busy = |valid.
- t_cfg_ack = 1 always; t_cfg_req is ignored.
- Reset (reset_n low at a clk edge):
  - valid=0, ptr=0, mode_q=2'b01, buf=0.
  - Outputs are then i_0_req=0, i_1_req=0, i_0_dat=0, i_1_dat=0, busy=0.
  - t_0_ack follows its equation (acks while reset_n is high and valid==0).
  - Reset mid-word discards remaining slots with no further beats. Reset overrides accept and fire in the same cycle.
- No combinational path from i_*_ack to i_*_req; the only ack->ack path is i_*_ack -> t_0_ack.

Test Plan:
- Single drain: W=8, mode=01, t_0_dat=0x44332211, acks held 1 -> t_0_ack in cycle 0; i_0_dat 0x11,0x22,0x33,0x44 in cycles 1-4; i_1_req stays 0; busy falls after cycle 4.
- Dual drain: mode=10, same word -> cycle 1 {i_0,i_1}={0x11,0x22}, cycle 2 {0x33,0x44}; then idle.
- Back-to-back: mode=10, t_0_req continuously high with words A, B -> B accepted on A's last-beat cycle; beats of A and B contiguous with no gap cycle.
- Backpressure and partial ack: dual, i_0_ack=1 and i_1_ack=0 for 3 cycles -> reqs and data hold, ptr unchanged; beat fires when i_1_ack=1.
- Mode 00 and mode change mid-word: accept with mode=01, switch to 00 after the first beat -> remaining 3 beats still single; t_0_ack stays 0 until mode returns to non-zero.
- Reset mid-word: reset_n low after 2 single beats -> next cycle i_0_req=0, busy=0; 0x33/0x44 never emitted; a new word is accepted in the first cycle after reset_n is released.

Source files
------------

// File: rtl/funnel_ctrl_1_3.sv
// funnel_ctrl_1_3: serialises one 4-slot wide word onto one (single) or two
// (dual) narrow initiator lanes; mirror of defunnel_ctrl_3_1.
module funnel_ctrl_1_3 #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           t_0_req,
    output logic           t_0_ack,
    input  logic [4*W-1:0] t_0_dat,
    input  logic           t_cfg_req,
    output logic           t_cfg_ack,
    output logic           i_0_req,
    input  logic           i_0_ack,
    output logic [W-1:0]   i_0_dat,
    output logic           i_1_req,
    input  logic           i_1_ack,
    output logic [W-1:0]   i_1_dat,
    input  logic [7:0]     mode,
    output logic           busy
);

    localparam int unsigned NSLOT = 4;
    localparam int unsigned PTR_W = 2;

    // Holding register, slot-valid mask, beat pointer and latched mode.
    logic [NSLOT*W-1:0] buf_q;
    logic [NSLOT-1:0]   valid_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [1:0]         mode_q;

    logic [W-1:0]       slot [NSLOT];
    logic [1:0]         reduct;
    logic [PTR_W-1:0]   ptr_p1;
    logic               dual_q;
    logic               fire;
    logic               last_fire;
    logic               accept;
    logic [NSLOT-1:0]   valid_clr;
    logic [PTR_W-1:0]   ptr_step;
    logic               unused_inputs;

    assign unused_inputs = ^{mode[7:2], t_cfg_req};

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        assign slot[k] = buf_q[k*W +: W];
    end

    assign reduct = mode[1:0];
    assign ptr_p1 = ptr_q + PTR_W'(1);
    // mode_q is never 00 (reset value 01, only non-zero modes are latched).
    assign dual_q = ~mode_q[0] & mode_q[1];

    // Beat presentation, handshake decode and word acceptance.
    always_comb begin
        i_0_req   = valid_q[ptr_q];
        i_0_dat   = slot[ptr_q];
        i_1_req   = 1'b0;
        i_1_dat   = '0;
        fire      = 1'b0;
        last_fire = 1'b0;
        valid_clr = '0;
        ptr_step  = PTR_W'(1);
        if (dual_q) begin
            i_1_req   = valid_q[ptr_p1];
            i_1_dat   = slot[ptr_p1];
            fire      = i_0_req & i_0_ack & i_1_req & i_1_ack;
            last_fire = fire & (ptr_q == PTR_W'(2));
            ptr_step  = PTR_W'(2);
            valid_clr[ptr_q]  = 1'b1;
            valid_clr[ptr_p1] = 1'b1;
        end else begin
            fire      = i_0_req & i_0_ack;
            last_fire = fire & (ptr_q == PTR_W'(3));
            valid_clr[ptr_q] = 1'b1;
        end
        accept    = t_0_req & (reduct != 2'b00) & ((valid_q == '0) | last_fire);
        t_0_ack   = accept;
        t_cfg_ack = 1'b1;
        busy      = |valid_q;
    end

    // State update: reset beats accept, accept beats the per-beat clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q   <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            mode_q  <= 2'b01;
        end else if (accept) begin
            buf_q   <= t_0_dat;
            valid_q <= '1;
            ptr_q   <= '0;
            mode_q  <= reduct;
        end else if (fire) begin
            valid_q <= valid_q & ~valid_clr;
            ptr_q   <= ptr_q + ptr_step;
        end
    end

endmodule

// File: tb/tb_funnel_ctrl_1_3.sv
// Directed self-checking bench for funnel_ctrl_1_3. Inputs change on the
// falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_funnel_ctrl_1_3;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           t_0_req;
    logic           t_0_ack;
    logic [4*W-1:0] t_0_dat;
    logic           t_cfg_req;
    logic           t_cfg_ack;
    logic           i_0_req;
    logic           i_0_ack;
    logic [W-1:0]   i_0_dat;
    logic           i_1_req;
    logic           i_1_ack;
    logic [W-1:0]   i_1_dat;
    logic [7:0]     mode;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    funnel_ctrl_1_3 #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .t_0_req   (t_0_req),
        .t_0_ack   (t_0_ack),
        .t_0_dat   (t_0_dat),
        .t_cfg_req (t_cfg_req),
        .t_cfg_ack (t_cfg_ack),
        .i_0_req   (i_0_req),
        .i_0_ack   (i_0_ack),
        .i_0_dat   (i_0_dat),
        .i_1_req   (i_1_req),
        .i_1_ack   (i_1_ack),
        .i_1_dat   (i_1_dat),
        .mode      (mode),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; caller then drives inputs and waits #1.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; t_0_req = 1'b0; t_0_dat = '0; t_cfg_req = 1'b1;
        i_0_ack = 1'b1; i_1_ack = 1'b1; mode = 8'h01;
        repeat (3) next_cycle();
        #1;
        n_cmp++; if ({i_0_req, i_1_req, busy} !== 3'b000) begin n_bad++;
            $display("FAIL reset_reqs got %b want 000", {i_0_req, i_1_req, busy}); end
        n_cmp++; if ({i_0_dat, i_1_dat} !== 16'h0000) begin n_bad++;
            $display("FAIL reset_dat got %h want 0000", {i_0_dat, i_1_dat}); end
        n_cmp++; if ({t_cfg_ack, t_0_ack} !== 2'b10) begin n_bad++;
            $display("FAIL reset_acks got %b want 10", {t_cfg_ack, t_0_ack}); end
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_single_drain();
        logic [W-1:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        next_cycle();
        mode = 8'hF5; t_0_req = 1'b1; t_0_dat = 32'h44332211;  // upper mode bits ignored
        #1;
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL single_accept got %b want 1", t_0_ack); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            t_0_req = 1'b0;
            #1;
            n_cmp++; if ({i_0_req, i_1_req, busy} !== 3'b101) begin n_bad++;
                $display("FAIL single_req beat %0d got %b want 101", k, {i_0_req, i_1_req, busy}); end
            n_cmp++; if ({i_0_dat, i_1_dat} !== {exp_b[k], 8'h00}) begin n_bad++;
                $display("FAIL single_dat beat %0d got %h want %h", k, {i_0_dat, i_1_dat}, {exp_b[k], 8'h00}); end
        end
        next_cycle();
        #1;
        n_cmp++; if ({i_0_req, busy} !== 2'b00) begin n_bad++;
            $display("FAIL single_idle got %b want 00", {i_0_req, busy}); end
    endtask

    task automatic test_dual_drain();
        logic [2*W-1:0] exp_p [2];
        exp_p = '{16'h1122, 16'h3344};
        next_cycle();
        mode = 8'h02; t_0_req = 1'b1; t_0_dat = 32'h44332211;
        #1;
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL dual_accept got %b want 1", t_0_ack); end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            t_0_req = 1'b0;
            #1;
            n_cmp++; if ({i_0_req, i_1_req} !== 2'b11) begin n_bad++;
                $display("FAIL dual_req beat %0d got %b want 11", k, {i_0_req, i_1_req}); end
            n_cmp++; if ({i_0_dat, i_1_dat} !== exp_p[k]) begin n_bad++;
                $display("FAIL dual_dat beat %0d got %h want %h", k, {i_0_dat, i_1_dat}, exp_p[k]); end
        end
        next_cycle();
        #1;
        n_cmp++; if ({i_0_req, i_1_req, busy} !== 3'b000) begin n_bad++;
            $display("FAIL dual_idle got %b want 000", {i_0_req, i_1_req, busy}); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp_p [4];
        logic           exp_ack [4];
        exp_p   = '{16'hAABB, 16'hCCDD, 16'h2143, 16'h6587};
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0};
        next_cycle();
        mode = 8'h02; t_0_req = 1'b1; t_0_dat = 32'hDDCCBBAA;
        #1;
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL b2b_accept_a got %b want 1", t_0_ack); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            t_0_req = (k < 2); t_0_dat = 32'h87654321;
            #1;
            n_cmp++; if ({i_0_req, i_1_req} !== 2'b11) begin n_bad++;
                $display("FAIL b2b_req beat %0d got %b want 11", k, {i_0_req, i_1_req}); end
            n_cmp++; if ({i_0_dat, i_1_dat} !== exp_p[k]) begin n_bad++;
                $display("FAIL b2b_dat beat %0d got %h want %h", k, {i_0_dat, i_1_dat}, exp_p[k]); end
            n_cmp++; if (t_0_ack !== exp_ack[k]) begin n_bad++;
                $display("FAIL b2b_ack beat %0d got %b want %b", k, t_0_ack, exp_ack[k]); end
        end
        next_cycle();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL b2b_idle got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        next_cycle();
        mode = 8'h02; t_0_req = 1'b1; t_0_dat = 32'h04030201;
        i_0_ack = 1'b1; i_1_ack = 1'b0;
        #1;
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL bp_accept got %b want 1", t_0_ack); end
        // Lone lane-0 ack for 3 cycles, then joint ack on the 4th.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            t_0_req = 1'b0; i_1_ack = (k == 3);
            #1;
            n_cmp++; if ({i_0_req, i_1_req, i_0_dat, i_1_dat} !== 18'b11_0000_0001_0000_0010) begin n_bad++;
                $display("FAIL bp_hold cyc %0d got %b/%b %h/%h want 1/1 01/02", k, i_0_req, i_1_req, i_0_dat, i_1_dat); end
        end
        // Last beat held by lane 1: next word must wait for the joint ack.
        next_cycle();
        i_1_ack = 1'b0; t_0_req = 1'b1; t_0_dat = 32'h0D0C0B0A;
        #1;
        n_cmp++; if ({i_0_dat, i_1_dat} !== 16'h0304) begin n_bad++;
            $display("FAIL bp_last_dat got %h want 0304", {i_0_dat, i_1_dat}); end
        n_cmp++; if (t_0_ack !== 1'b0) begin n_bad++;
            $display("FAIL bp_last_noack got %b want 0", t_0_ack); end
        next_cycle();
        i_1_ack = 1'b1;
        #1;
        n_cmp++; if ({i_0_dat, i_1_dat, t_0_ack} !== {16'h0304, 1'b1}) begin n_bad++;
            $display("FAIL bp_last_fire got %h ack %b want 0304 ack 1", {i_0_dat, i_1_dat}, t_0_ack); end
        next_cycle();
        t_0_req = 1'b0;
        #1;
        n_cmp++; if ({i_0_dat, i_1_dat} !== 16'h0A0B) begin n_bad++;
            $display("FAIL bp_next_dat0 got %h want 0a0b", {i_0_dat, i_1_dat}); end
        next_cycle();
        #1;
        n_cmp++; if ({i_0_dat, i_1_dat} !== 16'h0C0D) begin n_bad++;
            $display("FAIL bp_next_dat1 got %h want 0c0d", {i_0_dat, i_1_dat}); end
        next_cycle();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL bp_idle got %b want 0", busy); end
    endtask

    task automatic test_mode_change();
        logic [W-1:0] exp_b [3];
        exp_b = '{8'h22, 8'h33, 8'h44};
        next_cycle();
        mode = 8'h01; t_0_req = 1'b1; t_0_dat = 32'h44332211;
        #1;
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL mc_accept got %b want 1", t_0_ack); end
        next_cycle();
        t_0_req = 1'b0;
        #1;
        n_cmp++; if (i_0_dat !== 8'h11) begin n_bad++;
            $display("FAIL mc_first got %h want 11", i_0_dat); end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            mode = 8'h00; t_0_req = 1'b1;
            #1;
            n_cmp++; if ({i_0_req, i_1_req, i_0_dat} !== {2'b10, exp_b[k]}) begin n_bad++;
                $display("FAIL mc_drain beat %0d got %b%b %h want 10 %h", k, i_0_req, i_1_req, i_0_dat, exp_b[k]); end
            n_cmp++; if (t_0_ack !== 1'b0) begin n_bad++;
                $display("FAIL mc_noack beat %0d got %b want 0", k, t_0_ack); end
        end
        next_cycle();
        #1;
        n_cmp++; if ({busy, t_0_ack} !== 2'b00) begin n_bad++;
            $display("FAIL mc_idle got %b want 00", {busy, t_0_ack}); end
        next_cycle();
        mode = 8'h01;
        #1;
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL mc_reaccept got %b want 1", t_0_ack); end
        next_cycle();
        t_0_req = 1'b0;
        repeat (4) next_cycle();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL mc_final_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_word();
        next_cycle();
        mode = 8'h01; t_0_req = 1'b1; t_0_dat = 32'h44332211;
        next_cycle();
        t_0_req = 1'b0;
        #1;
        n_cmp++; if (i_0_dat !== 8'h11) begin n_bad++;
            $display("FAIL rst_beat0 got %h want 11", i_0_dat); end
        next_cycle();
        #1;
        n_cmp++; if (i_0_dat !== 8'h22) begin n_bad++;
            $display("FAIL rst_beat1 got %h want 22", i_0_dat); end
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1; t_0_req = 1'b1; t_0_dat = 32'h88776655;
        #1;
        n_cmp++; if ({i_0_req, busy, i_0_dat} !== 10'b0) begin n_bad++;
            $display("FAIL rst_cleared got %b%b %h want 00 00", i_0_req, busy, i_0_dat); end
        n_cmp++; if (t_0_ack !== 1'b1) begin n_bad++;
            $display("FAIL rst_reaccept got %b want 1", t_0_ack); end
        next_cycle();
        t_0_req = 1'b0;
        #1;
        n_cmp++; if ({i_0_req, i_0_dat} !== {1'b1, 8'h55}) begin n_bad++;
            $display("FAIL rst_newword got %b %h want 1 55", i_0_req, i_0_dat); end
        repeat (4) next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_drain();
        test_dual_drain();
        test_back_to_back();
        test_backpressure();
        test_mode_change();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
